// File: rtl/axi_fsrc_seq_pkg.sv
// Shared constants for the double-buffered FSRC sequencer register map:
// word addresses, COMMIT/STATUS bit positions and the commit FSM states.
package axi_fsrc_seq_pkg;

  localparam logic [13:0] ADDR_VERSION    = 14'h000;
  localparam logic [13:0] ADDR_ID         = 14'h001;
  localparam logic [13:0] ADDR_SCRATCH    = 14'h002;
  localparam logic [13:0] ADDR_MAGIC      = 14'h003;
  localparam logic [13:0] ADDR_GPIO_CNT   = 14'h004;
  localparam logic [13:0] ADDR_FIRST_TRIG = 14'h005;
  localparam logic [13:0] ADDR_SEQ_CTRL   = 14'h006;
  localparam logic [13:0] ADDR_COMMIT     = 14'h007;
  localparam logic [13:0] ADDR_STATUS     = 14'h008;
  localparam logic [13:0] ADDR_TRIG_OUT   = 14'h009;
  localparam logic [13:0] ADDR_GPIO_BASE  = 14'h010;

  localparam int CMD_COMMIT_NOW = 0;
  localparam int CMD_ARM        = 1;
  localparam int CMD_ABORT      = 2;
  localparam int CMD_START      = 3;

  localparam int STAT_ARMED       = 0;
  localparam int STAT_START_ARMED = 1;
  localparam int STAT_CNT_LSB     = 16;

  localparam int SEQ_EN_BIT      = 1;
  localparam int SEQ_NFD_BIT     = 4;
  localparam int SEQ_EXT_BIT     = 8;
  localparam int SEQ_ACCUM_LSB   = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } seq_state_e;

  function automatic int gpio_words(input int width);
    return (width + 31) / 32;
  endfunction

endpackage

// File: rtl/axi_fsrc_seq_commit_ctrl.sv
// Commit sequencing: IDLE/ARMED FSM, external commit edge detect, commit and
// start pulse generation and the wrapping 16-bit commit counter.
module axi_fsrc_seq_commit_ctrl
  import axi_fsrc_seq_pkg::*;
(
  input  logic        up_clk,
  input  logic        up_rstn,
  input  logic        cmd_wr,
  input  logic [3:0]  cmd,
  input  logic        ext_commit_i,
  output logic        commit,
  output logic        commit_pulse,
  output logic        seq_start,
  output logic        armed,
  output logic        start_armed,
  output logic [15:0] commit_cnt
);

  seq_state_e  state_r;
  seq_state_e  state_nxt_s;
  logic        start_armed_r;
  logic        start_armed_nxt_s;
  logic        ext_prev_r;
  logic        ext_rise_s;
  logic        commit_s;
  logic        start_s;
  logic        commit_pulse_r;
  logic        seq_start_r;
  logic [15:0] commit_cnt_r;

  assign ext_rise_s = ext_commit_i & ~ext_prev_r;

  // Next-state: COMMIT_NOW beats everything, an armed ext edge beats ARM/ABORT.
  always_comb begin
    state_nxt_s       = state_r;
    start_armed_nxt_s = start_armed_r;
    commit_s          = 1'b0;
    start_s           = 1'b0;
    if (cmd_wr && cmd[CMD_COMMIT_NOW]) begin
      commit_s          = 1'b1;
      start_s           = cmd[CMD_START];
      state_nxt_s       = ST_IDLE;
      start_armed_nxt_s = 1'b0;
    end else if ((state_r == ST_ARMED) && ext_rise_s) begin
      commit_s          = 1'b1;
      start_s           = start_armed_r;
      state_nxt_s       = ST_IDLE;
      start_armed_nxt_s = 1'b0;
    end else if (cmd_wr && cmd[CMD_ARM] && !cmd[CMD_ABORT]) begin
      state_nxt_s       = ST_ARMED;
      start_armed_nxt_s = cmd[CMD_START];
    end else if (cmd_wr && cmd[CMD_ABORT]) begin
      state_nxt_s       = ST_IDLE;
      start_armed_nxt_s = 1'b0;
    end else begin
      state_nxt_s       = state_r;
      start_armed_nxt_s = start_armed_r;
    end
  end

  // State, edge history, pulses and commit counter.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_r        <= ST_IDLE;
      start_armed_r  <= 1'b0;
      ext_prev_r     <= 1'b0;
      commit_pulse_r <= 1'b0;
      seq_start_r    <= 1'b0;
      commit_cnt_r   <= 16'h0000;
    end else begin
      state_r        <= state_nxt_s;
      start_armed_r  <= start_armed_nxt_s;
      ext_prev_r     <= ext_commit_i;
      commit_pulse_r <= commit_s;
      seq_start_r    <= start_s;
      if (commit_s) begin
        commit_cnt_r <= commit_cnt_r + 16'd1;
      end
    end
  end

  assign commit       = commit_s;
  assign commit_pulse = commit_pulse_r;
  assign seq_start    = seq_start_r;
  assign armed        = (state_r == ST_ARMED);
  assign start_armed  = start_armed_r;
  assign commit_cnt   = commit_cnt_r;

endmodule

// File: rtl/axi_fsrc_sequencer_regmap_shadow.sv
// FSRC sequencer register map with shadow/active double buffering; software
// writes the shadow copy, a commit moves every shadow field to the outputs.
module axi_fsrc_sequencer_regmap_shadow
  import axi_fsrc_seq_pkg::*;
#(
  parameter int          ID            = 0,
  parameter logic [31:0] CORE_VERSION  = 32'h0,
  parameter logic [31:0] CORE_MAGIC    = 32'h0,
  parameter int          CTRL_WIDTH    = 40,
  parameter int          COUNTER_WIDTH = 4,
  parameter int          NUM_TRIG      = 4
) (
  input  logic                                     up_clk,
  input  logic                                     up_rstn,
  input  logic                                     up_wreq,
  input  logic [13:0]                              up_waddr,
  input  logic [31:0]                              up_wdata,
  output logic                                     up_wack,
  input  logic                                     up_rreq,
  input  logic [13:0]                              up_raddr,
  output logic [31:0]                              up_rdata,
  output logic                                     up_rack,
  input  logic                                     ext_commit_i,
  output logic [31:0]                              reg_o_seq_gpio_change_cnt,
  output logic [NUM_TRIG-1:0][COUNTER_WIDTH-1:0]   reg_o_first_trig_cnt,
  output logic                                     reg_o_seq_en,
  output logic                                     reg_o_tx_sequencer_non_fsrc_delay_en,
  output logic                                     reg_o_seq_ext_trig_en,
  output logic [COUNTER_WIDTH-1:0]                 reg_o_seq_tx_accum_reset_cnt,
  output logic [CTRL_WIDTH-1:0]                    reg_o_dut_seq_gpio_w,
  output logic [NUM_TRIG-1:0]                      reg_o_trig_out,
  output logic                                     reg_o_seq_start,
  output logic                                     reg_o_commit_pulse
);

  localparam int GPIO_WORDS = gpio_words(CTRL_WIDTH);

  if ((NUM_TRIG * COUNTER_WIDTH > 32) || (NUM_TRIG < 1) || (NUM_TRIG > 32) ||
      (COUNTER_WIDTH < 1) || (COUNTER_WIDTH > 16) ||
      (CTRL_WIDTH < 1) || (CTRL_WIDTH > 512)) begin : g_bad_params
    $error("axi_fsrc_sequencer_regmap_shadow: illegal parameter combination");
  end

  logic [31:0]                            scratch_r;
  logic [NUM_TRIG-1:0]                    trig_out_r;
  logic [31:0]                            gpio_cnt_sh_r;
  logic [NUM_TRIG-1:0][COUNTER_WIDTH-1:0] first_trig_sh_r;
  logic                                   seq_en_sh_r;
  logic                                   nfd_en_sh_r;
  logic                                   ext_trig_sh_r;
  logic [COUNTER_WIDTH-1:0]               accum_sh_r;
  logic [CTRL_WIDTH-1:0]                  gpio_w_sh_r;
  logic [CTRL_WIDTH-1:0]                  gpio_w_sh_nxt_s;
  logic [GPIO_WORDS*32-1:0]               gpio_pad_s;
  logic [31:0]                            seq_ctrl_rd_s;
  logic [31:0]                            rd_data_s;
  logic                                   cmd_wr_s;
  logic                                   commit_s;
  logic                                   armed_s;
  logic                                   start_armed_s;
  logic [15:0]                            commit_cnt_s;

  assign cmd_wr_s = up_wreq && (up_waddr == ADDR_COMMIT);

  axi_fsrc_seq_commit_ctrl u_commit_ctrl (
    .up_clk       (up_clk),
    .up_rstn      (up_rstn),
    .cmd_wr       (cmd_wr_s),
    .cmd          (up_wdata[3:0]),
    .ext_commit_i (ext_commit_i),
    .commit       (commit_s),
    .commit_pulse (reg_o_commit_pulse),
    .seq_start    (reg_o_seq_start),
    .armed        (armed_s),
    .start_armed  (start_armed_s),
    .commit_cnt   (commit_cnt_s)
  );

  // GPIO shadow update; bits above CTRL_WIDTH simply have no storage.
  always_comb begin
    gpio_w_sh_nxt_s = gpio_w_sh_r;
    for (int b = 0; b < CTRL_WIDTH; b++) begin
      if (up_wreq && (up_waddr == ADDR_GPIO_BASE + 14'(b / 32))) begin
        gpio_w_sh_nxt_s[b] = up_wdata[b % 32];
      end else begin
        gpio_w_sh_nxt_s[b] = gpio_w_sh_r[b];
      end
    end
  end

  // Zero-padded GPIO shadow and packed SEQ_CTRL image for readback.
  always_comb begin
    gpio_pad_s                                      = '0;
    gpio_pad_s[CTRL_WIDTH-1:0]                      = gpio_w_sh_r;
    seq_ctrl_rd_s                                   = 32'h0;
    seq_ctrl_rd_s[SEQ_EN_BIT]                       = seq_en_sh_r;
    seq_ctrl_rd_s[SEQ_NFD_BIT]                      = nfd_en_sh_r;
    seq_ctrl_rd_s[SEQ_EXT_BIT]                      = ext_trig_sh_r;
    seq_ctrl_rd_s[SEQ_ACCUM_LSB +: COUNTER_WIDTH]   = accum_sh_r;
  end

  // Read mux; shadow addresses return the shadow, never the active copy.
  always_comb begin
    rd_data_s = 32'h0;
    case (up_raddr)
      ADDR_VERSION:    rd_data_s = CORE_VERSION;
      ADDR_ID:         rd_data_s = 32'(ID);
      ADDR_SCRATCH:    rd_data_s = scratch_r;
      ADDR_MAGIC:      rd_data_s = CORE_MAGIC;
      ADDR_GPIO_CNT:   rd_data_s = gpio_cnt_sh_r;
      ADDR_FIRST_TRIG: rd_data_s = 32'(first_trig_sh_r);
      ADDR_SEQ_CTRL:   rd_data_s = seq_ctrl_rd_s;
      ADDR_STATUS:     rd_data_s = {commit_cnt_s, 14'h0000, start_armed_s, armed_s};
      ADDR_TRIG_OUT:   rd_data_s = 32'(trig_out_r);
      default: begin
        rd_data_s = 32'h0;
        for (int k = 0; k < GPIO_WORDS; k++) begin
          if (up_raddr == ADDR_GPIO_BASE + 14'(k)) begin
            rd_data_s = gpio_pad_s[k*32 +: 32];
          end else begin
            rd_data_s = rd_data_s;
          end
        end
      end
    endcase
  end

  // Bus handshake, register writes and the shadow-to-active copy.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      up_wack                              <= 1'b0;
      up_rack                              <= 1'b0;
      up_rdata                             <= 32'h0;
      scratch_r                            <= 32'h0;
      trig_out_r                           <= '0;
      gpio_cnt_sh_r                        <= 32'h0;
      first_trig_sh_r                      <= '0;
      seq_en_sh_r                          <= 1'b0;
      nfd_en_sh_r                          <= 1'b0;
      ext_trig_sh_r                        <= 1'b0;
      accum_sh_r                           <= '0;
      gpio_w_sh_r                          <= '0;
      reg_o_seq_gpio_change_cnt            <= 32'h0;
      reg_o_first_trig_cnt                 <= '0;
      reg_o_seq_en                         <= 1'b0;
      reg_o_tx_sequencer_non_fsrc_delay_en <= 1'b0;
      reg_o_seq_ext_trig_en                <= 1'b0;
      reg_o_seq_tx_accum_reset_cnt         <= '0;
      reg_o_dut_seq_gpio_w                 <= '0;
    end else begin
      up_wack     <= up_wreq;
      up_rack     <= up_rreq;
      up_rdata    <= up_rreq ? rd_data_s : 32'h0;
      gpio_w_sh_r <= gpio_w_sh_nxt_s;
      if (up_wreq && (up_waddr == ADDR_SCRATCH)) begin
        scratch_r <= up_wdata;
      end
      if (up_wreq && (up_waddr == ADDR_TRIG_OUT)) begin
        trig_out_r <= up_wdata[NUM_TRIG-1:0];
      end
      if (up_wreq && (up_waddr == ADDR_GPIO_CNT)) begin
        gpio_cnt_sh_r <= up_wdata;
      end
      if (up_wreq && (up_waddr == ADDR_FIRST_TRIG)) begin
        first_trig_sh_r <= up_wdata[NUM_TRIG*COUNTER_WIDTH-1:0];
      end
      if (up_wreq && (up_waddr == ADDR_SEQ_CTRL)) begin
        seq_en_sh_r   <= up_wdata[SEQ_EN_BIT];
        nfd_en_sh_r   <= up_wdata[SEQ_NFD_BIT];
        ext_trig_sh_r <= up_wdata[SEQ_EXT_BIT];
        accum_sh_r    <= up_wdata[SEQ_ACCUM_LSB +: COUNTER_WIDTH];
      end
      // Right-hand sides are pre-write shadows, so a same-edge write lands next commit.
      if (commit_s) begin
        reg_o_seq_gpio_change_cnt            <= gpio_cnt_sh_r;
        reg_o_first_trig_cnt                 <= first_trig_sh_r;
        reg_o_seq_en                         <= seq_en_sh_r;
        reg_o_tx_sequencer_non_fsrc_delay_en <= nfd_en_sh_r;
        reg_o_seq_ext_trig_en                <= ext_trig_sh_r;
        reg_o_seq_tx_accum_reset_cnt         <= accum_sh_r;
        reg_o_dut_seq_gpio_w                 <= gpio_w_sh_r;
      end
    end
  end

  assign reg_o_trig_out = trig_out_r;

endmodule

// File: tb/tb_axi_fsrc_sequencer_regmap_shadow.sv
// Self-checking bench: read data is scoreboarded through a queue, outputs and
// pulses are compared inline by each scenario task.
module tb_axi_fsrc_sequencer_regmap_shadow;

  localparam logic [31:0] T_VERSION = 32'h0102_0304;
  localparam logic [31:0] T_MAGIC   = 32'hF5C0_ABCD;
  localparam int          T_ID      = 5;

  logic             up_clk = 1'b0;
  logic             up_rstn = 1'b0;
  logic             up_wreq = 1'b0;
  logic [13:0]      up_waddr = 14'h0;
  logic [31:0]      up_wdata = 32'h0;
  logic             up_wack;
  logic             up_rreq = 1'b0;
  logic [13:0]      up_raddr = 14'h0;
  logic [31:0]      up_rdata;
  logic             up_rack;
  logic             ext_commit_i = 1'b0;
  logic [31:0]      gpio_cnt;
  logic [3:0][3:0]  first_trig;
  logic             seq_en, nfd_en, ext_trig_en;
  logic [3:0]       accum;
  logic [39:0]      gpio_w;
  logic [3:0]       trig_out;
  logic             seq_start;
  logic             commit_pulse;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  rd_exp_t mon_e;
  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;

  axi_fsrc_sequencer_regmap_shadow #(
    .ID(T_ID), .CORE_VERSION(T_VERSION), .CORE_MAGIC(T_MAGIC),
    .CTRL_WIDTH(40), .COUNTER_WIDTH(4), .NUM_TRIG(4)
  ) dut (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .ext_commit_i(ext_commit_i),
    .reg_o_seq_gpio_change_cnt(gpio_cnt),
    .reg_o_first_trig_cnt(first_trig),
    .reg_o_seq_en(seq_en),
    .reg_o_tx_sequencer_non_fsrc_delay_en(nfd_en),
    .reg_o_seq_ext_trig_en(ext_trig_en),
    .reg_o_seq_tx_accum_reset_cnt(accum),
    .reg_o_dut_seq_gpio_w(gpio_w),
    .reg_o_trig_out(trig_out),
    .reg_o_seq_start(seq_start),
    .reg_o_commit_pulse(commit_pulse)
  );

  always #5 up_clk = ~up_clk;

  // Read-data scoreboard: every acknowledged read pops one expectation.
  always begin
    @(posedge up_clk);
    #1;
    if (up_rack) begin
      vectors++;
      if (rd_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected: ack with data %h, none expected", up_rdata);
      end else begin
        mon_e = rd_q.pop_front();
        if (up_rdata !== mon_e.data) begin
          miscompares++;
          $display("FAIL rd_%h: got %h expected %h", mon_e.addr, up_rdata, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge up_clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    up_wreq = 1'b1; up_waddr = a; up_wdata = d;
    tick();
    up_wreq = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, input logic [31:0] e);
    rd_exp_t x;
    x.addr = a; x.data = e;
    rd_q.push_back(x);
    up_rreq = 1'b1; up_raddr = a;
    tick();
    up_rreq = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && rd_q.size() != 0; i++) tick();
    if (rd_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL rd_timeout: %0d reads outstanding, expected 0", rd_q.size());
      rd_q.delete();
    end
  endtask

  task automatic test_reset();
    up_rstn = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({gpio_cnt, first_trig, seq_en, nfd_en, ext_trig_en, accum, gpio_w, trig_out,
         seq_start, commit_pulse, up_wack, up_rack, up_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    up_rstn = 1'b1;
    tick();
    rd(14'h000, T_VERSION);
    rd(14'h001, 32'(T_ID));
    rd(14'h003, T_MAGIC);
    rd(14'h008, 32'h0);
    rd(14'h00A, 32'h0);
    drain();
    tick();
    vectors++;
    if (up_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rdata_idle: got %h expected 00000000", up_rdata);
    end
  endtask

  task automatic test_shadow();
    wr(14'h004, 32'h1234_5678);
    wr(14'h010, 32'hDEAD_BEEF);
    wr(14'h011, 32'hFFFF_FFFF);
    wr(14'h005, 32'hFFFF_4321);
    wr(14'h006, 32'hFFFF_FFFF);
    wr(14'h002, 32'hA5A5_5A5A);
    wr(14'h000, 32'hFFFF_FFFF);
    vectors++;
    if ({gpio_cnt, first_trig, seq_en, nfd_en, ext_trig_en, accum, gpio_w, commit_pulse} !== '0) begin
      miscompares++;
      $display("FAIL shadow_no_leak: active outputs changed before commit, expected 0");
    end
    rd(14'h004, 32'h1234_5678);
    rd(14'h010, 32'hDEAD_BEEF);
    rd(14'h011, 32'h0000_00FF);
    rd(14'h012, 32'h0);
    rd(14'h005, 32'h0000_4321);
    rd(14'h006, 32'h000F_0112);
    rd(14'h002, 32'hA5A5_5A5A);
    rd(14'h000, T_VERSION);
    rd(14'h007, 32'h0);
    drain();
  endtask

  task automatic test_commit_now();
    wr(14'h007, 32'h0000_0009);
    exp_cnt++;
    vectors++;
    if (up_wack !== 1'b1 || commit_pulse !== 1'b1 || seq_start !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_now_pulses: got wack/commit/start %b%b%b expected 111",
               up_wack, commit_pulse, seq_start);
    end
    vectors++;
    if (gpio_cnt !== 32'h1234_5678 || gpio_w !== 40'hFF_DEAD_BEEF) begin
      miscompares++;
      $display("FAIL commit_now_gpio: got %h/%h expected 12345678/ffdeadbeef", gpio_cnt, gpio_w);
    end
    vectors++;
    if (first_trig !== 16'h4321 || {seq_en, nfd_en, ext_trig_en, accum} !== 7'b111_1111) begin
      miscompares++;
      $display("FAIL commit_now_ctrl: got %h/%b expected 4321/1111111",
               first_trig, {seq_en, nfd_en, ext_trig_en, accum});
    end
    tick();
    vectors++;
    if (commit_pulse !== 1'b0 || seq_start !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_now_one_cycle: got commit/start %b%b expected 00", commit_pulse, seq_start);
    end
    rd(14'h008, {16'(exp_cnt), 16'h0});
    drain();
  endtask

  task automatic test_trig_out();
    wr(14'h009, 32'hFFFF_FFFA);
    vectors++;
    if (trig_out !== 4'hA || commit_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL trig_out_direct: got %h/%b expected a/0", trig_out, commit_pulse);
    end
    rd(14'h009, 32'h0000_000A);
    drain();
  endtask

  task automatic test_arm_ext();
    int pulses = 0;
    int starts = 0;
    wr(14'h004, 32'hCAFE_0001);
    wr(14'h006, 32'h0000_0002);
    wr(14'h007, 32'h0000_000A);
    vectors++;
    if (commit_pulse !== 1'b0 || gpio_cnt !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL arm_no_commit: got %b/%h expected 0/12345678", commit_pulse, gpio_cnt);
    end
    rd(14'h008, {16'(exp_cnt), 16'h0003});
    drain();
    ext_commit_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) ext_commit_i = 1'b0;
      pulses += int'(commit_pulse);
      starts += int'(seq_start);
    end
    exp_cnt++;
    vectors++;
    if (pulses != 1 || starts != 1) begin
      miscompares++;
      $display("FAIL ext_single_commit: got %0d commits %0d starts expected 1 1", pulses, starts);
    end
    vectors++;
    if (gpio_cnt !== 32'hCAFE_0001 || {seq_en, nfd_en, ext_trig_en, accum} !== 7'b100_0000) begin
      miscompares++;
      $display("FAIL ext_commit_values: got %h/%b expected cafe0001/1000000",
               gpio_cnt, {seq_en, nfd_en, ext_trig_en, accum});
    end
    rd(14'h008, {16'(exp_cnt), 16'h0});
    drain();
  endtask

  task automatic test_abort();
    int pulses = 0;
    wr(14'h007, 32'h0000_0002);
    wr(14'h007, 32'h0000_0004);
    ext_commit_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) ext_commit_i = 1'b0;
      pulses += int'(commit_pulse);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL abort_blocks_ext: got %0d commits expected 0", pulses);
    end
    wr(14'h007, 32'h0000_0008);
    vectors++;
    if (commit_pulse !== 1'b0 || seq_start !== 1'b0) begin
      miscompares++;
      $display("FAIL start_alone: got commit/start %b%b expected 00", commit_pulse, seq_start);
    end
    wr(14'h004, 32'h0BAD_0BAD);
    wr(14'h007, 32'h0000_0002);
    ext_commit_i = 1'b1;
    wr(14'h007, 32'h0000_0004);
    exp_cnt++;
    vectors++;
    if (commit_pulse !== 1'b1 || seq_start !== 1'b0 || gpio_cnt !== 32'h0BAD_0BAD) begin
      miscompares++;
      $display("FAIL abort_vs_ext: got %b%b/%h expected 10/0bad0bad", commit_pulse, seq_start, gpio_cnt);
    end
    ext_commit_i = 1'b0;
    tick();
    rd(14'h008, {16'(exp_cnt), 16'h0});
    drain();
  endtask

  task automatic test_same_cycle_write();
    wr(14'h004, 32'h2222_0001);
    wr(14'h007, 32'h0000_0002);
    ext_commit_i = 1'b1;
    wr(14'h004, 32'h3333_0002);
    exp_cnt++;
    ext_commit_i = 1'b0;
    vectors++;
    if (commit_pulse !== 1'b1 || gpio_cnt !== 32'h2222_0001) begin
      miscompares++;
      $display("FAIL same_cycle_active: got %b/%h expected 1/22220001", commit_pulse, gpio_cnt);
    end
    rd(14'h004, 32'h3333_0002);
    drain();
  endtask

  task automatic test_back_to_back_wrap();
    int n;
    n = 65535 - exp_cnt;
    up_wreq = 1'b1; up_waddr = 14'h007; up_wdata = 32'h0000_0001;
    repeat (n) tick();
    up_wreq = 1'b0;
    vectors++;
    if (commit_pulse !== 1'b1 || gpio_cnt !== 32'h3333_0002) begin
      miscompares++;
      $display("FAIL back_to_back: got %b/%h expected 1/33330002", commit_pulse, gpio_cnt);
    end
    rd(14'h008, 32'hFFFF_0000);
    drain();
    wr(14'h007, 32'h0000_0001);
    exp_cnt = 0;
    tick();
    rd(14'h008, 32'h0000_0000);
    drain();
  endtask

  task automatic test_reset_armed();
    int pulses = 0;
    wr(14'h007, 32'h0000_000A);
    rd(14'h008, 32'h0000_0003);
    drain();
    up_rstn = 1'b0;
    tick();
    vectors++;
    if (gpio_cnt !== 32'h0 || commit_pulse !== 1'b0 || trig_out !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_armed_clear: got %h/%b/%h expected 0/0/0", gpio_cnt, commit_pulse, trig_out);
    end
    up_rstn = 1'b1;
    tick();
    ext_commit_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) ext_commit_i = 1'b0;
      pulses += int'(commit_pulse);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL reset_armed_no_commit: got %0d commits expected 0", pulses);
    end
    rd(14'h008, 32'h0);
    drain();
  endtask

  initial begin
    test_reset();
    test_shadow();
    test_commit_now();
    test_trig_out();
    test_arm_ext();
    test_abort();
    test_same_cycle_write();
    test_back_to_back_wrap();
    test_reset_armed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_fsrc_sequencer_regmap_shadow.md
Name: axi_fsrc_sequencer_regmap_shadow

Overview:
Parametrised successor to the FSRC sequencer register map. Single up_clk domain; all sequencer controls are double-buffered (shadow written by software, active drives outputs). Shadow is copied to active atomically, either on software command or on an armed external commit event. Adds a self-clearing start pulse, commit status and a commit counter. Sits between up_axi and the FSRC sequencer core.

Parameters:
ID, 0, core instance ID, read at 0x01
CORE_VERSION, 32'h0, read at 0x00
CORE_MAGIC, 32'h0, read at 0x03
CTRL_WIDTH, 40, GPIO control width, 1..512; GPIO_WORDS = ceil(CTRL_WIDTH/32) (localparam)
COUNTER_WIDTH, 4, width of each first-trigger count and of the accumulator-reset count, 1..16
NUM_TRIG, 4, trigger channels, 1..32; NUM_TRIG*COUNTER_WIDTH <= 32 (elaboration error otherwise)

Ports:
up_clk  in  1  register clock, only clock
up_rstn  in  1  asynchronous, active-low reset
up_wreq / up_waddr / up_wdata  in  1/14/32  up write request
up_wack  out  1  write ack
up_rreq / up_raddr  in  1/14  up read request
up_rdata / up_rack  out  32/1  read data / ack
ext_commit_i  in  1  external commit event, synchronous to up_clk
reg_o_seq_gpio_change_cnt  out  32  active
reg_o_first_trig_cnt  out  [NUM_TRIG-1:0][COUNTER_WIDTH-1:0]  active
reg_o_seq_en, reg_o_tx_sequencer_non_fsrc_delay_en, reg_o_seq_ext_trig_en  out  1 each  active
reg_o_seq_tx_accum_reset_cnt  out  COUNTER_WIDTH  active
reg_o_dut_seq_gpio_w  out  CTRL_WIDTH  active
reg_o_trig_out  out  NUM_TRIG  direct, not shadowed
reg_o_seq_start  out  1  one-cycle pulse
reg_o_commit_pulse  out  1  one-cycle pulse per commit

Behaviour:
- Reset (async assert, sync release): every register, output and counter = 0; FSM = IDLE.
- up_wack <= up_wreq, up_rack <= up_rreq (1-cycle latency). up_rdata = 0 when no read is active; unmapped addresses read 0; writes to RO or unmapped addresses are ignored.
- Register map (word addresses):
  - 0x00 VERSION, 0x01 ID, 0x03 MAGIC: RO.
  - 0x02 SCRATCH: RW.
  - 0x04 GPIO_CHANGE_CNT: shadow, RW.
  - 0x05 FIRST_TRIG: shadow; field i at [i*COUNTER_WIDTH +: COUNTER_WIDTH]; unused bits read 0.
  - 0x06 SEQ_CTRL: shadow. [1] en, [4] non_fsrc_delay_en, [8] ext_trig_en, [16 +: COUNTER_WIDTH] accum_reset_cnt.
  - 0x07 COMMIT: write-only command. [0] COMMIT_NOW, [1] ARM, [2] ABORT, [3] START. Reads return 0.
  - 0x08 STATUS: RO. [0] armed, [1] start_armed, [31:16] commit_cnt.
  - 0x09 TRIG_OUT: RW; drives reg_o_trig_out directly.
  - 0x10 .. 0x10+GPIO_WORDS-1 GPIO_W: shadow; word k maps to bits [32k +: 32]; bits above CTRL_WIDTH are not stored and read 0.
- Reads of shadow addresses return the shadow value, not the active value.
- FSM IDLE/ARMED. ext_commit event = rising edge of ext_commit_i (registered previous value; previous value resets to 0).
  - Write COMMIT_NOW=1: commit at that edge. Active outputs change in the cycle up_wack is high. FSM -> IDLE.
  - Write ARM=1, COMMIT_NOW=0, ABORT=0: IDLE/ARMED -> ARMED; start_armed <= START.
  - Write ABORT=1 without COMMIT_NOW: -> IDLE, start_armed <= 0.
  - COMMIT_NOW has priority over ARM and ABORT.
  - In ARMED, ext_commit event: commit, -> IDLE. An ext event in the same cycle as ABORT still commits (the event wins). In IDLE, ext events are ignored.
- Commit: all shadow fields copied to active at one edge; reg_o_commit_pulse = 1 for the next cycle. commit_cnt increments and wraps 0xFFFF -> 0.
- Shadow write in the same cycle as a commit: active takes the pre-write shadow; the shadow takes the new data.
- reg_o_seq_start pulses 1 cycle coincident with reg_o_commit_pulse when START was set with COMMIT_NOW, or start_armed at an ext commit. START alone (no COMMIT_NOW or ARM) produces no pulse.
- Reset mid-ARMED: FSM -> IDLE, no commit pulse.

Decomposition:
- Package axi_fsrc_seq_pkg: register address constants, COMMIT/STATUS bit indices, FSM state enum, GPIO_WORDS function.
- One sub-module axi_fsrc_seq_commit_ctrl: FSM, edge detect, pulse generation, commit_cnt. The register file stays in the top.

Test Plan:
- Reset, then read 0x00/0x01/0x03/0x08 -> CORE_VERSION/ID/CORE_MAGIC/0; all outputs 0.
- Write 0x04=0x12345678, 0x10=0xDEADBEEF, 0x11=0xFF -> outputs stay 0; read 0x11 returns 0x000000FF.
- Write 0x07=0x9 -> next cycle reg_o_seq_gpio_change_cnt=0x12345678, reg_o_dut_seq_gpio_w=40'hFFDEADBEEF, commit_pulse and seq_start high for exactly 1 cycle; STATUS[31:16]=1.
- Write 0x07=0xA, pulse ext_commit_i high for 3 cycles -> exactly one commit and one start pulse; STATUS[0]=0 afterwards.
- ARM, then ABORT, then ext pulse -> no commit; separately ABORT and ext edge in the same cycle -> commit occurs.
- 65536 commits -> commit_cnt wraps to 0; shadow write in the same cycle as ext commit -> active holds the old value, shadow reads back the new value.
